// File: rtl/gain_ramp_stage.sv
// gain_ramp_stage: per-lane Q2.14 gain with rounding/saturation behind a two-register valid/ready pipeline.
// Define GAIN_RAMP_STAGE_RAMP_EN for linear gain ramping; without it gain changes take effect at once.
module gain_ramp_stage #(
    parameter int WD_IN  = 24,
    parameter int WD_OUT = 24,
    parameter int N_CH   = 2,
    parameter int STEP   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3*N_CH-1:0]        sel_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WD_IN*N_CH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WD_OUT*N_CH-1:0]   out_data,
    output logic [N_CH-1:0]          ramp_busy,
    output logic [N_CH-1:0]          sat_flag,
    input  logic                     sat_clr
);

    localparam int PW = WD_IN + 17;
    localparam logic signed [PW-1:0] RND_HALF = PW'(8192);
    localparam logic signed [PW-1:0] OUT_MAX  = PW'((64'sd1 <<< (WD_OUT - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] OUT_MIN  = -OUT_MAX - PW'(1);

    if (STEP < 1 || STEP > 16384) begin : g_step_check
        $error("gain_ramp_stage: STEP must lie in 1..16384");
    end

    function automatic logic [15:0] target_of(input logic [2:0] code);
        case (code)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h1000;
            3'd2:    return 16'h2000;
            3'd3:    return 16'h4000;
            3'd4:    return 16'h8000;
            default: return 16'h4000;
        endcase
    endfunction

    logic adv;
    logic acc;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign acc      = in_valid && adv;

    logic [15:0] tgt        [N_CH];
    logic [15:0] frame_gain [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign tgt[i] = target_of(sel_in[3*i +: 3]);
`ifdef GAIN_RAMP_STAGE_RAMP_EN
        localparam logic [15:0] STEP_W = 16'(STEP);
        logic [15:0] cur_gain;
        logic [15:0] tgt_q;
        logic [15:0] cur_next;

        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
        always_comb begin
            cur_next = cur_gain;
            if (cur_gain < tgt[i])
                cur_next = (tgt[i] - cur_gain > STEP_W) ? cur_gain + STEP_W : tgt[i];
            else if (cur_gain > tgt[i])
                cur_next = (cur_gain - tgt[i] > STEP_W) ? cur_gain - STEP_W : tgt[i];
        end

        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cur_gain <= 16'h0000;
                tgt_q    <= 16'h0000;
            end else if (acc) begin
                cur_gain <= cur_next;
                tgt_q    <= tgt[i];
            end
        end

        // The frame being accepted uses the gain from before this acceptance's ramp step.
        assign frame_gain[i] = cur_gain;
        assign ramp_busy[i]  = (cur_gain != tgt_q);
`else
        assign frame_gain[i] = tgt[i];
        assign ramp_busy[i]  = 1'b0;
`endif
    end

    logic                      s1_valid;
    logic signed [WD_IN-1:0]   s1_data [N_CH];
    logic        [15:0]        s1_gain [N_CH];

    logic signed [PW-1:0]      prod    [N_CH];
    logic signed [PW-1:0]      rnd     [N_CH];
    logic        [WD_OUT-1:0]  sat_val [N_CH];
    logic        [N_CH-1:0]    clamp;

    always_comb begin
        clamp = '0;
        for (int i = 0; i < N_CH; i++) begin
            prod[i]    = s1_data[i] * $signed({1'b0, s1_gain[i]});
            rnd[i]     = (prod[i] + RND_HALF) >>> 14;
            sat_val[i] = rnd[i][WD_OUT-1:0];
            if (rnd[i] > OUT_MAX) begin
                sat_val[i] = OUT_MAX[WD_OUT-1:0];
                clamp[i]   = 1'b1;
            end else if (rnd[i] < OUT_MIN) begin
                sat_val[i] = OUT_MIN[WD_OUT-1:0];
                clamp[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= '0;
            // NOTE: the per-lane stage-1 arrays are small flops, so they are reset too; this keeps X off the datapath.
            for (int i = 0; i < N_CH; i++) begin
                s1_data[i] <= '0;
                s1_gain[i] <= '0;
            end
        end else begin
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    for (int i = 0; i < N_CH; i++) begin
                        s1_data[i] <= in_data[WD_IN*i +: WD_IN];
                        s1_gain[i] <= frame_gain[i];
                    end
                end
                if (s1_valid) begin
                    for (int i = 0; i < N_CH; i++)
                        out_data[WD_OUT*i +: WD_OUT] <= sat_val[i];
                end
            end
            // A new clamp wins over a simultaneous clear.
            sat_flag <= (sat_clr ? {N_CH{1'b0}} : sat_flag) | ((adv && s1_valid) ? clamp : {N_CH{1'b0}});
        end
    end

endmodule
